// File: rtl/read_command_issue_queue.sv
// Read command issue queue: buffers read-engine commands in a FIFO and issues them
// to the PSL command interface while command credits remain.
module read_command_issue_queue #(
  parameter int unsigned CMD_W         = 64,
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned MAX_CREDITS   = 64,
  parameter int unsigned ALFULL_MARGIN = 2
) (
  input  logic                     clock,
  input  logic                     rstn,
  input  logic                     enable_in,
  input  logic                     cmd_in_valid,
  input  logic [CMD_W-1:0]         cmd_in_payload,
  input  logic                     credit_init_valid,
  input  logic [7:0]               credit_init_value,
  input  logic                     rsp_credit_valid,
  output logic                     cmd_out_valid,
  output logic [CMD_W-1:0]         cmd_out_payload,
  output logic                     buf_empty,
  output logic                     buf_full,
  output logic                     buf_alfull,
  output logic [$clog2(DEPTH):0]   buf_count,
  output logic [7:0]               credits_avail,
  output logic [7:0]               outstanding,
  output logic                     err_overflow,
  output logic                     err_credit
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullLevel   = CW'(DEPTH);
  localparam logic [CW-1:0] AlfullLevel = CW'(DEPTH - ALFULL_MARGIN);
  localparam logic [7:0]    MaxCred     = 8'(MAX_CREDITS);

  typedef enum logic [1:0] {StInit, StRun, StHalt} state_e;

  state_e              state_q, state_d;
  logic [CMD_W-1:0]    mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q, count_d;
  logic [7:0]          credits_q, credits_d;
  logic [7:0]          outstanding_q, outstanding_d;
  logic                out_valid_q;
  logic [CMD_W-1:0]    out_payload_q;
  logic                err_overflow_q, err_credit_q;
  logic                full, do_issue, do_push, ret_ok;

  assign full     = (count_q == FullLevel);
  assign do_issue = (state_q == StRun) && enable_in && (count_q != '0) && (credits_q != '0);
  // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted.
  assign do_push  = cmd_in_valid && (!full || do_issue);
  assign ret_ok   = rsp_credit_valid && (outstanding_q != '0);

  always_comb begin
    state_d       = state_q;
    credits_d     = credits_q;
    outstanding_d = outstanding_q;
    count_d       = count_q;

    unique case (state_q)
      StInit: begin
        if (credit_init_valid) begin
          credits_d = (credit_init_value > MaxCred) ? MaxCred : credit_init_value;
          state_d   = enable_in ? StRun : StHalt;
        end
      end
      StRun:   if (!enable_in) state_d = StHalt;
      StHalt:  if (enable_in)  state_d = StRun;
      default: state_d = StInit;
    endcase

    if (do_issue && !ret_ok) begin
      credits_d     = credits_q - 8'd1;
      outstanding_d = outstanding_q + 8'd1;
    end else if (ret_ok && !do_issue) begin
      outstanding_d = outstanding_q - 8'd1;
      credits_d     = (credits_q >= MaxCred) ? MaxCred : credits_q + 8'd1;
    end

    if (do_push && !do_issue)      count_d = count_q + CW'(1);
    else if (do_issue && !do_push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clock) begin
    if (rstn) begin
      state_q        <= StInit;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      credits_q      <= '0;
      outstanding_q  <= '0;
      out_valid_q    <= 1'b0;
      err_overflow_q <= 1'b0;
      err_credit_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      credits_q     <= credits_d;
      outstanding_q <= outstanding_d;
      out_valid_q   <= do_issue;
      if (do_push)  wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_issue) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (cmd_in_valid && !do_push)             err_overflow_q <= 1'b1;
      if (rsp_credit_valid && !ret_ok)          err_credit_q   <= 1'b1;
    end
  end

  // Storage and issued payload need no reset; payload is qualified by cmd_out_valid.
  always_ff @(posedge clock) begin
    if (!rstn && do_push)  mem_q[wr_ptr_q] <= cmd_in_payload;
    if (!rstn && do_issue) out_payload_q   <= mem_q[rd_ptr_q];
  end

  assign cmd_out_valid   = out_valid_q;
  assign cmd_out_payload = out_payload_q;
  assign buf_empty       = (count_q == '0);
  assign buf_full        = full;
  assign buf_alfull      = (count_q >= AlfullLevel);
  assign buf_count       = count_q;
  assign credits_avail   = credits_q;
  assign outstanding     = outstanding_q;
  assign err_overflow    = err_overflow_q;
  assign err_credit      = err_credit_q;

endmodule

// File: tb/tb_read_command_issue_queue.sv
// Scoreboard bench for read_command_issue_queue: expected payloads are queued at push time
// and matched against every cmd_out_valid pulse.
module tb_read_command_issue_queue;

  localparam int unsigned CMD_W = 64;
  localparam int unsigned DEPTH = 16;

  logic             clock = 1'b0;
  logic             rstn;
  logic             enable_in;
  logic             cmd_in_valid;
  logic [CMD_W-1:0] cmd_in_payload;
  logic             credit_init_valid;
  logic [7:0]       credit_init_value;
  logic             rsp_credit_valid;
  logic             cmd_out_valid;
  logic [CMD_W-1:0] cmd_out_payload;
  logic             buf_empty, buf_full, buf_alfull;
  logic [4:0]       buf_count;
  logic [7:0]       credits_avail, outstanding;
  logic             err_overflow, err_credit;

  int n_tests = 0;
  int n_fail  = 0;
  int n_issued = 0;
  int base;
  logic [CMD_W-1:0] sb[$];

  read_command_issue_queue #(
    .CMD_W(CMD_W), .DEPTH(DEPTH), .MAX_CREDITS(64), .ALFULL_MARGIN(2)
  ) dut (
    .clock(clock), .rstn(rstn), .enable_in(enable_in),
    .cmd_in_valid(cmd_in_valid), .cmd_in_payload(cmd_in_payload),
    .credit_init_valid(credit_init_valid), .credit_init_value(credit_init_value),
    .rsp_credit_valid(rsp_credit_valid),
    .cmd_out_valid(cmd_out_valid), .cmd_out_payload(cmd_out_payload),
    .buf_empty(buf_empty), .buf_full(buf_full), .buf_alfull(buf_alfull),
    .buf_count(buf_count), .credits_avail(credits_avail), .outstanding(outstanding),
    .err_overflow(err_overflow), .err_credit(err_credit)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b1;
    sb.delete();
    tick();
    rstn = 1'b0;
  endtask

  task automatic init_credits(input logic [7:0] value, input logic en);
    enable_in         = en;
    credit_init_valid = 1'b1;
    credit_init_value = value;
    tick();
    credit_init_valid = 1'b0;
  endtask

  task automatic push(input logic [CMD_W-1:0] p, input bit expect_accept);
    cmd_in_valid   = 1'b1;
    cmd_in_payload = p;
    if (expect_accept) sb.push_back(p);
    tick();
    cmd_in_valid = 1'b0;
  endtask

  // Return one credit per cycle whenever something is outstanding.
  task automatic drain(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      rsp_credit_valid = (outstanding != 8'd0);
      tick();
    end
    rsp_credit_valid = 1'b0;
  endtask

  always @(negedge clock) begin
    if (cmd_out_valid) begin
      n_issued++;
      if (sb.size() == 0) check_eq("spurious_issue", {63'd0, cmd_out_valid}, 64'd0);
      else check_eq("issue_payload", cmd_out_payload, sb.pop_front());
    end
  end

  initial begin
    rstn = 1'b1; enable_in = 1'b0; cmd_in_valid = 1'b0; cmd_in_payload = '0;
    credit_init_valid = 1'b0; credit_init_value = '0; rsp_credit_valid = 1'b0;
    tick(); tick();
    check_eq("rst_empty", {63'd0, buf_empty}, 64'd1);
    check_eq("rst_full", {63'd0, buf_full}, 64'd0);
    check_eq("rst_alfull", {63'd0, buf_alfull}, 64'd0);
    check_eq("rst_count", {59'd0, buf_count}, 64'd0);
    check_eq("rst_valid", {63'd0, cmd_out_valid}, 64'd0);
    check_eq("rst_credits", {56'd0, credits_avail}, 64'd0);
    check_eq("rst_outstanding", {56'd0, outstanding}, 64'd0);
    check_eq("rst_err", {62'd0, err_overflow, err_credit}, 64'd0);
    rstn = 1'b0;

    // Four credits, six commands: only four issue.
    init_credits(8'd4, 1'b1);
    for (int i = 1; i <= 6; i++) push(CMD_W'(i), 1'b1);
    repeat (8) tick();
    check_eq("t1_issued", 64'(n_issued), 64'd4);
    check_eq("t1_credits", {56'd0, credits_avail}, 64'd0);
    check_eq("t1_outstanding", {56'd0, outstanding}, 64'd4);
    check_eq("t1_count", {59'd0, buf_count}, 64'd2);

    // Two returns release the last two; second return coincides with an issue.
    rsp_credit_valid = 1'b1;
    tick();
    check_eq("t2_credit_after_ret", {56'd0, credits_avail}, 64'd1);
    tick();
    rsp_credit_valid = 1'b0;
    check_eq("t2_same_cycle_credits", {56'd0, credits_avail}, 64'd1);
    check_eq("t2_same_cycle_outst", {56'd0, outstanding}, 64'd3);
    repeat (4) tick();
    check_eq("t2_issued", 64'(n_issued), 64'd6);
    check_eq("t2_empty", {63'd0, buf_empty}, 64'd1);
    check_eq("t2_outstanding", {56'd0, outstanding}, 64'd4);
    check_eq("t2_credits", {56'd0, credits_avail}, 64'd0);

    // Fill while halted, overflow, then drain in order.
    do_reset();
    init_credits(8'd8, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      push(CMD_W'(32'h200 + i), 1'b1);
      if (i == 13) check_eq("t3_alfull_13", {63'd0, buf_alfull}, 64'd0);
      if (i == 14) check_eq("t3_alfull_14", {63'd0, buf_alfull}, 64'd1);
    end
    check_eq("t3_full", {63'd0, buf_full}, 64'd1);
    push(CMD_W'(32'hdead), 1'b0);
    check_eq("t3_overflow", {63'd0, err_overflow}, 64'd1);
    check_eq("t3_count_after_drop", {59'd0, buf_count}, 64'd16);
    base = n_issued;
    enable_in = 1'b1;
    repeat (12) tick();
    check_eq("t3_first_batch", 64'(n_issued - base), 64'd8);
    check_eq("t3_count_mid", {59'd0, buf_count}, 64'd8);
    check_eq("t3_credits_mid", {56'd0, credits_avail}, 64'd0);
    drain(40);
    check_eq("t3_total", 64'(n_issued - base), 64'd16);
    check_eq("t3_empty", {63'd0, buf_empty}, 64'd1);
    check_eq("t3_sb_left", 64'(sb.size()), 64'd0);

    // Push into a full FIFO in the same cycle as an issue.
    do_reset();
    init_credits(8'd8, 1'b0);
    for (int i = 1; i <= 16; i++) push(CMD_W'(32'h300 + i), 1'b1);
    enable_in = 1'b1;
    tick();
    check_eq("t4_full_before", {63'd0, buf_full}, 64'd1);
    push(CMD_W'(32'h3ff), 1'b1);
    check_eq("t4_count", {59'd0, buf_count}, 64'd16);
    check_eq("t4_no_overflow", {63'd0, err_overflow}, 64'd0);
    drain(60);
    check_eq("t4_sb_left", 64'(sb.size()), 64'd0);
    check_eq("t4_outstanding", {56'd0, outstanding}, 64'd0);
    check_eq("t4_credits", {56'd0, credits_avail}, 64'd8);

    // Spurious credit return.
    rsp_credit_valid = 1'b1;
    tick();
    rsp_credit_valid = 1'b0;
    check_eq("t5_err_credit", {63'd0, err_credit}, 64'd1);
    check_eq("t5_credits_kept", {56'd0, credits_avail}, 64'd8);

    // Reset with commands queued, then nothing issues until credits are loaded.
    enable_in = 1'b0;
    tick();
    for (int i = 1; i <= 5; i++) push(CMD_W'(32'h400 + i), 1'b1);
    do_reset();
    check_eq("t6_valid", {63'd0, cmd_out_valid}, 64'd0);
    check_eq("t6_empty", {63'd0, buf_empty}, 64'd1);
    check_eq("t6_credits", {56'd0, credits_avail}, 64'd0);
    check_eq("t6_err", {62'd0, err_overflow, err_credit}, 64'd0);
    enable_in = 1'b1;
    push(CMD_W'(32'h501), 1'b1);
    push(CMD_W'(32'h502), 1'b1);
    base = n_issued;
    repeat (6) tick();
    check_eq("t6_no_issue_init", 64'(n_issued - base), 64'd0);
    check_eq("t6_count", {59'd0, buf_count}, 64'd2);
    init_credits(8'd200, 1'b1);
    repeat (6) tick();
    check_eq("t6_issued", 64'(n_issued - base), 64'd2);
    check_eq("t6_credit_clamp", {56'd0, credits_avail}, 64'd62);
    check_eq("t6_sb_left", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/read_command_issue_queue.md
Name: read_command_issue_queue

Overview:
- Downstream neighbour of the read engine.
- Buffers read commands from the read engine in a FIFO and issues them to the PSL command interface only while PSL command credits are available.
- Tracks credits returned by responses and the number of outstanding commands.
- Drives the command buffer status (empty/full/almost-full) back to the read engine for flow control.

Parameters:
- CMD_W, 64: width of the flattened command payload (tag, command, address, size).
- DEPTH, 16: FIFO entries; power of two.
- MAX_CREDITS, 64: credit counter ceiling.
- ALFULL_MARGIN, 2: almost-full asserts when count >= DEPTH-ALFULL_MARGIN.

Ports:
- clock  in  1  rising-edge clock
- rstn  in  1  synchronous reset, active-high (1 = reset), sampled on clock
- enable_in  in  1  issue enable; 0 halts issue only
- cmd_in_valid  in  1  command push strobe from read engine
- cmd_in_payload  in  CMD_W  command payload
- credit_init_valid  in  1  PSL initial command room strobe
- credit_init_value  in  8  initial credit count (croom)
- rsp_credit_valid  in  1  one response returned; restores one credit
- cmd_out_valid  out  1  registered issue strobe to PSL
- cmd_out_payload  out  CMD_W  issued payload, valid with cmd_out_valid
- buf_empty  out  1  FIFO empty
- buf_full  out  1  FIFO full
- buf_alfull  out  1  FIFO almost full
- buf_count  out  $clog2(DEPTH)+1  occupancy
- credits_avail  out  8  current credits
- outstanding  out  8  commands issued minus responses returned
- err_overflow  out  1  sticky: push while full
- err_credit  out  1  sticky: credit return with outstanding==0

Behaviour:
- Reset (rstn=1 at an edge): FIFO pointers/count cleared.
  - buf_empty=1; buf_full=0; buf_alfull=0; buf_count=0.
  - cmd_out_valid=0; credits_avail=0; outstanding=0; err_*=0; state=S_INIT.
  - cmd_out_payload is don't-care.
  - Reset mid-operation discards queued commands and in-flight accounting with no further issue.
- States:
  - S_INIT: no issue. credit_init_valid -> load credits_avail=min(credit_init_value, MAX_CREDITS); go to S_RUN if enable_in else S_HALT.
  - S_RUN: issue permitted. enable_in=0 -> S_HALT.
  - S_HALT: no issue; pushes and credit returns still processed. enable_in=1 -> S_RUN.
  - credit_init_valid outside S_INIT is ignored.
- Push: cmd_in_valid=1 and buf_full=0 writes the payload at the tail. cmd_in_valid=1 with buf_full=1 drops the command and sets err_overflow.
- Issue condition in cycle t: state==S_RUN, enable_in=1, buf_empty=0, credits_avail>0.
  - Effect: pop the head; cmd_out_valid=1 with that payload at edge t+1; credits_avail-1; outstanding+1.
  - At most one issue per cycle; minimum latency push->issue is 2 cycles (push edge, then issue edge).
- Simultaneous push and pop:
  - Allowed when full: the pop frees the slot, so the push is accepted and count is unchanged.
  - When empty, the push is not bypassed; it issues the following cycle.
- Credit return: rsp_credit_valid with outstanding>0 -> outstanding-1; credits_avail+1, saturating at MAX_CREDITS.
  - rsp_credit_valid with outstanding==0 -> err_credit set; counters unchanged.
  - Issue and return in the same cycle leave credits_avail and outstanding unchanged.
- Status outputs are registered and reflect occupancy after that edge's push/pop.
  - buf_alfull = count >= DEPTH-ALFULL_MARGIN.
  - buf_full = count==DEPTH.
  - Pointers wrap modulo DEPTH; count distinguishes full from empty.
- Error flags clear only on reset.

Test Plan:
- Reset, credit_init_value=4, enable_in=1, push 6 commands (payloads 1..6) back-to-back -> cmd_out_valid pulses carry 1,2,3,4 in order; issue stops; credits_avail=0; outstanding=4; buf_count=2.
- From that state, 2 rsp_credit_valid pulses -> payloads 5,6 issue; buf_empty=1; outstanding=4; credits_avail=0.
- enable_in=0, credits=8, push 16 -> buf_full=1; buf_alfull at count 14. A 17th push -> err_overflow=1 and the command is dropped. enable_in=1 -> exactly 16 pops, in order (capped by credits: 8 issue, then 8 more after 8 returns).
- FIFO full plus simultaneous push and issue -> buf_count stays 16; new payload appears at the tail and issues last; err_overflow stays 0.
- Same-cycle issue and rsp_credit_valid with credits_avail=1 -> credits_avail stays 1 and issue continues next cycle.
- rsp_credit_valid with outstanding=0 -> err_credit=1. Assert rstn mid-stream with 5 queued -> next cycle cmd_out_valid=0, buf_empty=1, credits_avail=0, state S_INIT; no issue until credit_init_valid.
